// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares the framebuffer RAM port between the display scanner and buffered CPU traffic.
// Define VGA_ARB_STARVE_GUARD_EN to let a full write FIFO take one scanner slot after STARVE_LIMIT grants.
module vga_mem_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_we,
    input  logic              cpu_re,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              force_drain;
    logic              scan_grant;
    logic              cpu_rd_grant;
    logic              drain;
    logic              push;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_wdata;
    logic              vga_pend;
    logic              cpu_pend;

    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);

    // A CPU read waits for an empty FIFO so it always sees every earlier store.
    always_comb begin
        scan_grant   = !reset && vga_req && !force_drain;
        cpu_rd_grant = !reset && cpu_re && !cpu_we && fifo_empty && !vga_req;
        drain        = !reset && !scan_grant && !cpu_rd_grant && !fifo_empty;
        push         = !reset && cpu_we && !fifo_full;
    end

    assign cpu_stall = reset || (cpu_we ? fifo_full : (cpu_re && !cpu_rd_grant));

    always_comb begin
        mem_addr  = last_addr;
        mem_wdata = last_wdata;
        mem_we    = drain;
        if (reset) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end else if (scan_grant) begin
            mem_addr = vga_addr;
        end else if (cpu_rd_grant) begin
            mem_addr = cpu_addr;
        end else if (drain) begin
            mem_addr  = fifo_addr[head];
            mem_wdata = fifo_data[head];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_addr  <= '0;
            last_wdata <= '0;
            vga_pend   <= 1'b0;
            cpu_pend   <= 1'b0;
        end else begin
            last_addr  <= mem_addr;
            last_wdata <= mem_wdata;
            vga_pend   <= scan_grant;
            cpu_pend   <= cpu_rd_grant;
        end
    end

    assign vga_rvalid = vga_pend;
    assign cpu_rvalid = cpu_pend;
    assign vga_rdata  = vga_pend ? mem_rdata : '0;
    assign cpu_rdata  = cpu_pend ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[tail] <= cpu_addr;
            fifo_data[tail] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)  tail <= tail + 1'b1;
            if (drain) head <= head + 1'b1;
            case ({push, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef VGA_ARB_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    logic [SC_W-1:0] starve_cnt;

    // Only scanner wins against a full FIFO count toward starvation.
    assign force_drain = (starve_cnt >= SC_W'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (scan_grant && fifo_full) begin
            starve_cnt <= starve_cnt + 1'b1;
        end else begin
            starve_cnt <= '0;
        end
    end
`else
    assign force_drain = 1'b0;
`endif
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter with a synchronous RAM model on the memory port.
module tb_vga_mem_arbiter;
    localparam int AW = 11;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_we, cpu_re;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic          vga_rvalid;
    logic [DW-1:0] vga_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vga_req = 1'b0; vga_addr = '0;
        tick(); tick();
        cpu_we = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b1) begin
            errors++; $display("FAIL reset_stall got %b want 1", cpu_stall);
        end
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b0, 11'h000, 8'h00}) begin
            errors++; $display("FAIL reset_mem got we=%b addr=%h wdata=%h want 0/0/0", mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if ({vga_rvalid, cpu_rvalid, vga_rdata, cpu_rdata} !== 18'h0) begin
            errors++; $display("FAIL reset_rd got vv=%b cv=%b vd=%h cd=%h want all 0", vga_rvalid, cpu_rvalid, vga_rdata, cpu_rdata);
        end
        tick();
        reset = 1'b0; cpu_we = 1'b0;
        tick();
    endtask

    task automatic test_store_basic();
        for (int i = 0; i < 4; i++) begin
            cpu_we = 1'b1; cpu_addr = AW'(i); cpu_wdata = DW'(8'hA0 + i);
            @(negedge clk);
            checks++;
            if (cpu_stall !== 1'b0) begin
                errors++; $display("FAIL store_stall[%0d] got %b want 0", i, cpu_stall);
            end
            checks++;
            if (i == 0 && mem_we !== 1'b0) begin
                errors++; $display("FAIL store_first_we got %b want 0", mem_we);
            end else if (i > 0 && {mem_we, mem_addr, mem_wdata} !== {1'b1, AW'(i - 1), DW'(8'hA0 + i - 1)}) begin
                errors++; $display("FAIL store_drain[%0d] got we=%b addr=%h data=%h want 1/%h/%h",
                                   i, mem_we, mem_addr, mem_wdata, i - 1, 8'hA0 + i - 1);
            end
            tick();
        end
        cpu_we = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 11'h003, 8'hA3}) begin
            errors++; $display("FAIL store_last got we=%b addr=%h data=%h want 1/003/a3", mem_we, mem_addr, mem_wdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({mem_we, mem_addr} !== {1'b0, 11'h003}) begin
            errors++; $display("FAIL store_idle got we=%b addr=%h want 0/003", mem_we, mem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ram[i] !== DW'(8'hA0 + i)) begin
                errors++; $display("FAIL store_ram[%0d] got %h want %h", i, ram[i], 8'hA0 + i);
            end
        end
        tick();
    endtask

    task automatic test_full_stall();
        vga_req = 1'b1; vga_addr = 11'h100;
        for (int k = 0; k < 5; k++) begin
            cpu_we = 1'b1; cpu_addr = AW'(16 + k); cpu_wdata = DW'(8'hB0 + k);
            @(negedge clk);
            checks++;
            if (cpu_stall !== (k == 4)) begin
                errors++; $display("FAIL full_stall[%0d] got %b want %b", k, cpu_stall, k == 4);
            end
            checks++;
            if ({mem_we, mem_addr} !== {1'b0, 11'h100}) begin
                errors++; $display("FAIL full_scan[%0d] got we=%b addr=%h want 0/100", k, mem_we, mem_addr);
            end
            if (k < 4) tick();
        end
        tick();
        @(negedge clk);
        checks++;
        if ({cpu_stall, mem_we, vga_rvalid} !== 3'b101) begin
            errors++; $display("FAIL full_hold got stall=%b we=%b vrv=%b want 1/0/1", cpu_stall, mem_we, vga_rvalid);
        end
        tick();
        vga_req = 1'b0;
        for (int d = 0; d < 5; d++) begin
            @(negedge clk);
            checks++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, AW'(16 + d), DW'(8'hB0 + d)}) begin
                errors++; $display("FAIL full_drain[%0d] got we=%b addr=%h data=%h want 1/%h/%h",
                                   d, mem_we, mem_addr, mem_wdata, 16 + d, 8'hB0 + d);
            end
            if (d < 2) begin
                checks++;
                if ({cpu_stall, vga_rvalid} !== {d == 0, d == 0}) begin
                    errors++; $display("FAIL full_accept[%0d] got stall=%b vrv=%b want %b/%b", d, cpu_stall, vga_rvalid, d == 0, d == 0);
                end
            end
            tick();
            if (d == 1) cpu_we = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0) begin
            errors++; $display("FAIL full_empty_we got %b want 0", mem_we);
        end
        tick();
    endtask

    task automatic test_raw_order();
        cpu_we = 1'b1; cpu_addr = 11'h007; cpu_wdata = 8'h55;
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b0) begin
            errors++; $display("FAIL raw_push got stall=%b want 0", cpu_stall);
        end
        tick();
        cpu_we = 1'b0; cpu_re = 1'b1;
        @(negedge clk);
        checks++;
        if ({cpu_stall, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 11'h007, 8'h55}) begin
            errors++; $display("FAIL raw_wait got stall=%b we=%b addr=%h data=%h want 1/1/007/55", cpu_stall, mem_we, mem_addr, mem_wdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({cpu_stall, mem_we, mem_addr} !== {1'b0, 1'b0, 11'h007}) begin
            errors++; $display("FAIL raw_grant got stall=%b we=%b addr=%h want 0/0/007", cpu_stall, mem_we, mem_addr);
        end
        tick();
        cpu_re = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_rvalid, cpu_rdata, vga_rvalid} !== {1'b1, 8'h55, 1'b0}) begin
            errors++; $display("FAIL raw_data got crv=%b crd=%h vrv=%b want 1/55/0", cpu_rvalid, cpu_rdata, vga_rvalid);
        end
        tick();
    endtask

    task automatic test_vga_priority();
        vga_req = 1'b1; vga_addr = 11'h002; cpu_re = 1'b1; cpu_addr = 11'h003;
        @(negedge clk);
        checks++;
        if ({cpu_stall, mem_we, mem_addr} !== {1'b1, 1'b0, 11'h002}) begin
            errors++; $display("FAIL prio_scan got stall=%b we=%b addr=%h want 1/0/002", cpu_stall, mem_we, mem_addr);
        end
        tick();
        vga_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({vga_rvalid, vga_rdata, cpu_rvalid, cpu_rdata} !== {1'b1, 8'hA2, 1'b0, 8'h00}) begin
            errors++; $display("FAIL prio_vdata got vrv=%b vrd=%h crv=%b crd=%h want 1/a2/0/00", vga_rvalid, vga_rdata, cpu_rvalid, cpu_rdata);
        end
        checks++;
        if ({cpu_stall, mem_addr} !== {1'b0, 11'h003}) begin
            errors++; $display("FAIL prio_cpu got stall=%b addr=%h want 0/003", cpu_stall, mem_addr);
        end
        tick();
        cpu_re = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_rvalid, cpu_rdata, vga_rvalid, vga_rdata} !== {1'b1, 8'hA3, 1'b0, 8'h00}) begin
            errors++; $display("FAIL prio_cdata got crv=%b crd=%h vrv=%b vrd=%h want 1/a3/0/00", cpu_rvalid, cpu_rdata, vga_rvalid, vga_rdata);
        end
        tick();
    endtask

    task automatic test_we_and_re();
        cpu_we = 1'b1; cpu_re = 1'b1; cpu_addr = 11'h009; cpu_wdata = 8'h99;
        @(negedge clk);
        checks++;
        if ({cpu_stall, mem_we, mem_addr} !== {1'b0, 1'b0, 11'h003}) begin
            errors++; $display("FAIL wr_only got stall=%b we=%b addr=%h want 0/0/003", cpu_stall, mem_we, mem_addr);
        end
        tick();
        cpu_we = 1'b0; cpu_re = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_rvalid, mem_we, mem_addr, mem_wdata} !== {1'b0, 1'b1, 11'h009, 8'h99}) begin
            errors++; $display("FAIL wr_only_drain got crv=%b we=%b addr=%h data=%h want 0/1/009/99", cpu_rvalid, mem_we, mem_addr, mem_wdata);
        end
        tick();
    endtask

    task automatic test_starve();
        int drains;
        int exp_drains;
`ifdef VGA_ARB_STARVE_GUARD_EN
        exp_drains = 1;
`else
        exp_drains = 0;
`endif
        drains = 0;
        vga_req = 1'b1; vga_addr = 11'h200;
        for (int i = 0; i < 4; i++) begin
            cpu_we = 1'b1; cpu_addr = AW'(32 + i); cpu_wdata = DW'(8'hC0 + i);
            tick();
        end
        cpu_we = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_we === 1'b1) drains++;
            tick();
        end
        checks++;
        if (drains !== exp_drains) begin
            errors++; $display("FAIL starve_drains got %0d want %0d", drains, exp_drains);
        end
        vga_req = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        checks++;
        if ({mem_we, ram[32], ram[35]} !== {1'b0, 8'hC0, 8'hC3}) begin
            errors++; $display("FAIL starve_flush got we=%b r32=%h r35=%h want 0/c0/c3", mem_we, ram[32], ram[35]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        vga_req = 1'b1; vga_addr = 11'h002;
        for (int i = 0; i < 3; i++) begin
            cpu_we = 1'b1; cpu_addr = AW'(48 + i); cpu_wdata = DW'(8'hD0 + i);
            tick();
        end
        cpu_we = 1'b0; vga_req = 1'b0; reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({cpu_stall, mem_we} !== 2'b10) begin
            errors++; $display("FAIL rst_mid_gate got stall=%b we=%b want 1/0", cpu_stall, mem_we);
        end
        tick();
        reset = 1'b0; cpu_re = 1'b1; cpu_addr = 11'h007;
        @(negedge clk);
        checks++;
        if ({vga_rvalid, cpu_rvalid, mem_we, cpu_stall} !== 4'b0000) begin
            errors++; $display("FAIL rst_mid_after got vrv=%b crv=%b we=%b stall=%b want 0/0/0/0", vga_rvalid, cpu_rvalid, mem_we, cpu_stall);
        end
        tick();
        cpu_re = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (mem_we !== 1'b0) begin
                errors++; $display("FAIL rst_mid_nowr[%0d] got we=%b want 0", c, mem_we);
            end
            tick();
        end
        checks++;
        if (ram[48] !== 8'h00) begin
            errors++; $display("FAIL rst_mid_ram got %h want 00", ram[48]);
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) ram[a] = '0;
        mem_rdata = '0;
        test_reset();
        test_store_basic();
        test_full_stall();
        test_raw_order();
        test_vga_priority();
        test_we_and_re();
        test_starve();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
